gcn_transform_fsm: RTL and testbench

- Control FSM that sequences the feature × weight transformation stage of the GCN block.
- For each weight column it fetches the column from external memory into the scratch pad. It then walks every feature row, fetching each row and committing the resulting dot product into the FM_WM product memory at (row, col).
- Signals done once all FEATURE_ROWS × WEIGHT_COLS products are written.
- Sits between the top-level GCN start/done interface and the Scratch_Pad / Matrix_FM_WM_Memory datapath.

---
 rtl/gcn_transform_fsm.sv | 125 ++++++++++++
 tb/tb_gcn_transform_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gcn_transform_fsm.sv
// Sequencer for the GCN feature x weight transformation stage.
// Loads each weight column into the scratch pad, then writes one product per feature row.
module gcn_transform_fsm #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int ADDRESS_WIDTH         = 13,
    parameter int WEIGHT_ADDR_BASE      = 0,
    parameter int FEATURE_ADDR_BASE     = 512,
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic [ADDRESS_WIDTH-1:0]         read_address,
    output logic                             enable_read,
    output logic                             enable_scratch_pad,
    output logic                             enable_write_fm_wm_prod,
    output logic [COUNTER_FEATURE_WIDTH-1:0] fm_wm_write_row,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  fm_wm_write_col,
    output logic                             done
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_READ_W  | read strobe for weight column wcnt
    // S_LOAD_W  | capture returned column into the scratch pad
    // S_READ_F  | read strobe for feature row fcnt
    // S_WRITE_P | commit product (fcnt, wcnt)
    // S_DONE    | all products written; held until start drops
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_W,
        S_LOAD_W,
        S_READ_F,
        S_WRITE_P,
        S_DONE
    } state_t;

    localparam logic [COUNTER_FEATURE_WIDTH-1:0] F_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  W_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [ADDRESS_WIDTH-1:0]         W_BASE = ADDRESS_WIDTH'(WEIGHT_ADDR_BASE);
    localparam logic [ADDRESS_WIDTH-1:0]         F_BASE = ADDRESS_WIDTH'(FEATURE_ADDR_BASE);

    state_t                           state, state_nxt;
    logic [COUNTER_FEATURE_WIDTH-1:0] fcnt, fcnt_nxt;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  wcnt, wcnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            fcnt  <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_READ_W;
            end
            S_READ_W:  state_nxt = S_LOAD_W;
            S_LOAD_W:  state_nxt = S_READ_F;
            S_READ_F:  state_nxt = S_WRITE_P;
            S_WRITE_P: begin
                // Terminal-count compare so non-power-of-two sizes never wrap.
                if (fcnt != F_LAST) begin
                    fcnt_nxt  = fcnt + 1'b1;
                    state_nxt = S_READ_F;
                end else begin
                    fcnt_nxt = '0;
                    if (wcnt != W_LAST) begin
                        wcnt_nxt  = wcnt + 1'b1;
                        state_nxt = S_READ_W;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                    wcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                fcnt_nxt  = '0;
                wcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        read_address            = '0;
        enable_read             = 1'b0;
        enable_scratch_pad      = 1'b0;
        enable_write_fm_wm_prod = 1'b0;
        done                    = 1'b0;
        fm_wm_write_row         = fcnt;
        fm_wm_write_col         = wcnt;
        case (state)
            S_READ_W: begin
                enable_read  = 1'b1;
                read_address = W_BASE + ADDRESS_WIDTH'(wcnt);
            end
            S_LOAD_W:  enable_scratch_pad = 1'b1;
            S_READ_F: begin
                enable_read  = 1'b1;
                read_address = F_BASE + ADDRESS_WIDTH'(fcnt);
            end
            S_WRITE_P: enable_write_fm_wm_prod = 1'b1;
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_gcn_transform_fsm.sv
// Bench for gcn_transform_fsm: default sizing plus a 5x2 instance, against an event-list model.
module tb_gcn_transform_fsm;

    typedef struct packed {
        logic        rd;
        logic        sp;
        logic        wr;
        logic        dn;
        logic [12:0] addr;
        logic [2:0]  row;
        logic [1:0]  col;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;

    logic [12:0] a_addr, b_addr;
    logic        a_rd, a_sp, a_wr, a_dn, b_rd, b_sp, b_wr, b_dn;
    logic [2:0]  a_row, b_row;
    logic [1:0]  a_col;
    logic [0:0]  b_col;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gcn_transform_fsm dut_a (
        .clk(clk), .reset(reset), .start(start),
        .read_address(a_addr), .enable_read(a_rd), .enable_scratch_pad(a_sp),
        .enable_write_fm_wm_prod(a_wr), .fm_wm_write_row(a_row),
        .fm_wm_write_col(a_col), .done(a_dn)
    );

    gcn_transform_fsm #(.FEATURE_ROWS(5), .WEIGHT_COLS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .read_address(b_addr), .enable_read(b_rd), .enable_scratch_pad(b_sp),
        .enable_write_fm_wm_prod(b_wr), .fm_wm_write_row(b_row),
        .fm_wm_write_col(b_col), .done(b_dn)
    );

    ev_t obs;
    always_comb begin
        obs = '0;
        if (sel) obs = {b_rd, b_sp, b_wr, b_dn, b_addr, b_row, {1'b0, b_col}};
        else     obs = {a_rd, a_sp, a_wr, a_dn, a_addr, a_row, a_col};
    end

    // Expected per-cycle activity of one run, straight from the column/row walk.
    ev_t q[$];
    task automatic build_model(input int rows, input int cols);
        ev_t e;
        q.delete();
        for (int c = 0; c < cols; c++) begin
            e = '0; e.rd = 1; e.addr = 13'(c); e.col = 2'(c);
            q.push_back(e);
            e = '0; e.sp = 1; e.col = 2'(c);
            q.push_back(e);
            for (int r = 0; r < rows; r++) begin
                e = '0; e.rd = 1; e.addr = 13'(512 + r); e.row = 3'(r); e.col = 2'(c);
                q.push_back(e);
                e = '0; e.wr = 1; e.row = 3'(r); e.col = 2'(c);
                q.push_back(e);
            end
        end
    endtask

    function automatic ev_t mask(input ev_t o, input ev_t x);
        ev_t m = o;
        if (!x.rd) m.addr = '0;
        return m;
    endfunction

    task automatic idle_cycles(input int n);
        ev_t x;
        x = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== x) begin
                fails++;
                $display("FAIL idle cyc%0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    // Full run: start rises at a negedge, the following edge samples it.
    task automatic run_seq(input string name, input int rows, input int cols,
                           input bit glitch, input bit hold, input int stop_at);
        ev_t x;
        int  pulse;
        int  n;
        build_model(rows, cols);
        n = q.size();
        pulse = $urandom_range(1, 4);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hold) start = 1'b1;
            else if (glitch && i >= 2 + 2*rows && i < 2*(2 + 2*rows)) start = 1'($urandom);
            else if (i + 1 >= pulse) start = 1'b0;
            tests++;
            if (mask(obs, q[i]) !== q[i]) begin
                fails++;
                $display("FAIL %s cyc%0d got=%h exp=%h", name, i, obs, q[i]);
            end
            if (i == stop_at) return;
        end
        if (!hold) start = 1'b0;
        x = '0; x.dn = 1; x.col = 2'(cols - 1);
        for (int k = 0; k < (hold ? 4 : 1); k++) begin
            @(negedge clk);
            tests++;
            if (obs !== x) begin
                fails++;
                $display("FAIL %s_done k%0d got=%h exp=%h", name, k, obs, x);
            end
        end
        start = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            idle_cycles(5);
        end
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_full_run();
        run_seq("full", 6, 3, 1'b0, 1'b0, -1);
        idle_cycles($urandom_range(0, 3));
        run_seq("full2", 6, 3, 1'b0, 1'b0, -1);
    endtask

    task automatic test_start_held();
        run_seq("held1", 6, 3, 1'b0, 1'b1, -1);
        run_seq("held2", 6, 3, 1'b0, 1'b1, -1);
    endtask

    task automatic test_start_glitch();
        for (int t = 0; t < 3; t++) run_seq("glitch", 6, 3, 1'b1, 1'b0, -1);
    endtask

    task automatic test_mid_reset(input int stop_at);
        ev_t x;
        x = '0;
        run_seq("pre_rst", 6, 3, 1'b0, 1'b0, stop_at);
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        tests++;
        if (obs !== x) begin
            fails++;
            $display("FAIL mid_reset_async got=%h exp=%h", obs, x);
        end
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(2);
        run_seq("post_rst", 6, 3, 1'b0, 1'b0, -1);
    endtask

    task automatic test_small_size();
        sel = 1'b1;
        idle_cycles(1);
        run_seq("small", 5, 2, 1'b0, 1'b0, -1);
        run_seq("small_held", 5, 2, 1'b0, 1'b1, -1);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 4; t++) begin
            run_seq("b2b", 6, 3, 1'($urandom), 1'b0, -1);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_held();
        test_start_glitch();
        // WRITE_P of (row 3, col 1) is event 14 + 2 + 2*3 + 1.
        test_mid_reset(23);
        test_mid_reset($urandom_range(0, 41));
        test_small_size();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
